wb_bram_ctrl: RTL and testbench

Wishbone slave front-end that sits directly upstream of the user-project exmem block RAM. It decodes the exmem address window and converts Wishbone byte addresses to BRAM word addresses. It drives the BRAM single-port interface for one access cycle per transaction and returns a Wishbone ack after a fixed, parameterised latency. This emulates slow external memory for firmware running from exmem.

---
 rtl/wb_bram_ctrl.sv | 130 +++++++++++++
 tb/tb_wb_bram_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram_ctrl.sv
// Wishbone slave front-end for the exmem block RAM: decodes the address window,
// performs one BRAM access per transaction and acks after a fixed latency.
module wb_bram_ctrl #(
  parameter logic [31:0] ADDR_BASE = 32'h3800_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFC0_0000,
  parameter int unsigned DELAY     = 10,
  parameter int unsigned N         = 9
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_di,
  output logic [31:0] bram_a,
  input  logic [31:0] bram_do
);

  localparam logic [7:0] LAST_CNT = 8'(DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [N-1:0] adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;
  logic        ack_q;
  logic        en_q;
  logic [3:0]  bwe_q;

  logic        hit_s;
  logic        req_s;
  logic [7:0]  cnt_inc_s;

  function automatic logic [3:0] lane_we(input logic we, input logic [3:0] sel);
    return we ? sel : 4'b0000;
  endfunction

  assign hit_s     = ((wbs_adr_i & ADDR_MASK) == ADDR_BASE);
  assign req_s     = wbs_cyc_i & wbs_stb_i & hit_s;
  assign cnt_inc_s = cnt_q + 8'd1;

  // Transaction FSM; en/we are pre-computed one cycle ahead so they are registered
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      adr_q   <= '0;
      dat_q   <= 32'h0;
      sel_q   <= 4'b0000;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      en_q    <= 1'b0;
      bwe_q   <= 4'b0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ack_q <= 1'b0;
          if (req_s) begin
            adr_q   <= wbs_adr_i[N+1:2];
            dat_q   <= wbs_dat_i;
            sel_q   <= wbs_sel_i;
            we_q    <= wbs_we_i;
            cnt_q   <= 8'd1;
            state_q <= ST_WAIT;
            en_q    <= (LAST_CNT == 8'd1);
            bwe_q   <= (LAST_CNT == 8'd1) ? lane_we(wbs_we_i, wbs_sel_i) : 4'b0000;
          end else begin
            en_q  <= 1'b0;
            bwe_q <= 4'b0000;
          end
        end
        ST_WAIT: begin
          ack_q <= 1'b0;
          if (cnt_q == LAST_CNT) begin
            // Access cycle: commits regardless of the master still being present
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            cnt_q   <= 8'd0;
            en_q    <= 1'b0;
            bwe_q   <= 4'b0000;
          end else if (!(wbs_cyc_i && wbs_stb_i)) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            en_q    <= 1'b0;
            bwe_q   <= 4'b0000;
          end else begin
            cnt_q <= cnt_inc_s;
            en_q  <= (cnt_inc_s == LAST_CNT);
            bwe_q <= (cnt_inc_s == LAST_CNT) ? lane_we(we_q, sel_q) : 4'b0000;
          end
        end
        ST_ACK: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
          en_q    <= 1'b0;
          bwe_q   <= 4'b0000;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 8'd0;
          ack_q   <= 1'b0;
          en_q    <= 1'b0;
          bwe_q   <= 4'b0000;
        end
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = (ack_q && !we_q) ? bram_do : 32'h0;
  assign bram_en   = en_q;
  assign bram_we   = bwe_q;
  assign bram_di   = dat_q;
  assign bram_a    = {{(32 - N){1'b0}}, adr_q};

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Directed bench for wb_bram_ctrl: DELAY=10 instance for function/abort/reset,
// DELAY=2 instance for back-to-back reads, each with a behavioural BRAM.
module tb_wb_bram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        cyc_a = 1'b0, stb_a = 1'b0, we_a = 1'b0;
  logic [3:0]  sel_a = 4'h0;
  logic [31:0] adr_a = 32'h0, dati_a = 32'h0;
  logic        ack_a, en_a;
  logic [3:0]  bwe_a;
  logic [31:0] dato_a, bdi_a, ba_a, bdo_a;

  logic        cyc_b = 1'b0, stb_b = 1'b0, we_b = 1'b0;
  logic [3:0]  sel_b = 4'h0;
  logic [31:0] adr_b = 32'h0, dati_b = 32'h0;
  logic        ack_b, en_b;
  logic [3:0]  bwe_b;
  logic [31:0] dato_b, bdi_b, ba_b, bdo_b;

  logic [31:0] mem_a [512];
  logic [31:0] mem_b [512];
  logic [31:0] model_a [512];
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];

  wb_bram_ctrl #(.DELAY(10)) dut_a (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc_a), .wbs_stb_i(stb_a), .wbs_we_i(we_a), .wbs_sel_i(sel_a),
    .wbs_adr_i(adr_a), .wbs_dat_i(dati_a), .wbs_ack_o(ack_a), .wbs_dat_o(dato_a),
    .bram_en(en_a), .bram_we(bwe_a), .bram_di(bdi_a), .bram_a(ba_a), .bram_do(bdo_a)
  );

  wb_bram_ctrl #(.DELAY(2)) dut_b (
    .wb_clk_i(clk), .wb_rst_n(rst_n),
    .wbs_cyc_i(cyc_b), .wbs_stb_i(stb_b), .wbs_we_i(we_b), .wbs_sel_i(sel_b),
    .wbs_adr_i(adr_b), .wbs_dat_i(dati_b), .wbs_ack_o(ack_b), .wbs_dat_o(dato_b),
    .bram_en(en_b), .bram_we(bwe_b), .bram_di(bdi_b), .bram_a(ba_b), .bram_do(bdo_b)
  );

  // Single-port BRAMs with byte writes and registered read data
  always @(posedge clk) begin
    logic [31:0] w;
    if (en_a) begin
      w = mem_a[ba_a[8:0]];
      for (int b = 0; b < 4; b++) if (bwe_a[b]) w[8*b +: 8] = bdi_a[8*b +: 8];
      bdo_a <= mem_a[ba_a[8:0]];
      mem_a[ba_a[8:0]] <= w;
    end
  end

  always @(posedge clk) begin
    logic [31:0] w;
    if (en_b) begin
      w = mem_b[ba_b[8:0]];
      for (int b = 0; b < 4; b++) if (bwe_b[b]) w[8*b +: 8] = bdi_b[8*b +: 8];
      bdo_b <= mem_b[ba_b[8:0]];
      mem_b[ba_b[8:0]] <= w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the DELAY=10 port; abort_at/rst_at < 0 disables that event
  task automatic run_a(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int abort_at, input int rst_at);
    logic        hit;
    logic        completes;
    logic [8:0]  word;
    logic [31:0] merged;
    logic [3:0]  seen_we;
    logic [31:0] seen_a, seen_di, exp_d;
    int acks, ack_c, ens, en_c, limit;
    hit       = ((adr & 32'hFFC0_0000) == 32'h3800_0000);
    completes = hit && (abort_at < 0) && (rst_at < 0);
    word      = adr[10:2];
    if (completes) begin
      if (we) begin
        q_a.push_back(32'h0);
        merged = model_a[word];
        for (int b = 0; b < 4; b++) if (sel[b]) merged[8*b +: 8] = dat[8*b +: 8];
        model_a[word] = merged;
      end else begin
        q_a.push_back(model_a[word]);
      end
    end
    acks = 0; ack_c = -1; ens = 0; en_c = -1;
    seen_we = 4'h0; seen_a = 32'h0; seen_di = 32'h0;
    limit = completes ? 13 : 50;
    @(posedge clk); #1;
    cyc_a = 1'b1; stb_a = 1'b1; we_a = we; adr_a = adr; dati_a = dat; sel_a = sel;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (c == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_ack", {31'h0, ack_a}, 32'h0);
        chk("rst_dat", dato_a, 32'h0);
        chk("rst_en", {31'h0, en_a}, 32'h0);
        chk("rst_we", {28'h0, bwe_a}, 32'h0);
        chk("rst_a", ba_a, 32'h0);
        chk("rst_di", bdi_a, 32'h0);
        cyc_a = 1'b0; stb_a = 1'b0;
      end
      if (c == abort_at) begin
        cyc_a = 1'b0; stb_a = 1'b0;
      end
      if (en_a) begin
        ens++; en_c = c; seen_we = bwe_a; seen_a = ba_a; seen_di = bdi_a;
      end
      if (ack_a) begin
        acks++; ack_c = c;
        if (q_a.size() > 0) begin
          exp_d = q_a.pop_front();
          chk("ack_data", dato_a, exp_d);
        end
        cyc_a = 1'b0; stb_a = 1'b0;
      end
    end
    cyc_a = 1'b0; stb_a = 1'b0;
    rst_n = 1'b1;
    chk("ack_count", acks, completes ? 32'd1 : 32'd0);
    if (completes) begin
      chk("ack_cycle", ack_c, 32'd10);
      chk("en_count", ens, 32'd1);
      chk("en_cycle", en_c, 32'd9);
      chk("bram_we", {28'h0, seen_we}, {28'h0, (we ? sel : 4'h0)});
      chk("bram_a", seen_a, {23'h0, word});
      chk("bram_di", seen_di, dat);
    end else begin
      chk("no_access", ens, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] exp_d;
    int acks_b, first_c, second_c;
    for (int i = 0; i < 512; i++) begin
      mem_a[i] = 32'h0;
      model_a[i] = 32'h0;
      mem_b[i] = 32'hA5A5_0000 | i;
    end
    #1;
    chk("reset_ack", {31'h0, ack_a}, 32'h0);
    chk("reset_dat", dato_a, 32'h0);
    chk("reset_en", {31'h0, en_a}, 32'h0);
    chk("reset_we", {28'h0, bwe_a}, 32'h0);
    chk("reset_a", ba_a, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_a(1'b1, 32'h3800_0010, 32'hDEAD_BEEF, 4'hF, -1, -1);
    run_a(1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, -1);
    run_a(1'b1, 32'h3800_0020, 32'h0000_0000, 4'hF, -1, -1);
    run_a(1'b1, 32'h3800_0020, 32'h1122_3344, 4'b0101, -1, -1);
    run_a(1'b0, 32'h3800_0020, 32'h0, 4'hF, -1, -1);
    run_a(1'b0, 32'h3000_0000, 32'h0, 4'hF, -1, -1);
    run_a(1'b1, 32'h3800_0800, 32'hCAFE_F00D, 4'hF, -1, -1);
    run_a(1'b1, 32'h3800_0010, 32'h5555_5555, 4'hF, 5, -1);
    run_a(1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, -1);
    run_a(1'b1, 32'h3800_0010, 32'h7777_7777, 4'hF, -1, 4);
    run_a(1'b0, 32'h3800_0010, 32'h0, 4'hF, -1, -1);
    run_a(1'b0, 32'h3800_0020, 32'h0, 4'hF, -1, -1);

    // Back-to-back reads on the DELAY=2 port; stb re-raised after one idle cycle
    acks_b = 0; first_c = -1; second_c = -1;
    q_b.push_back(32'hA5A5_0003);
    @(posedge clk); #1;
    cyc_b = 1'b1; stb_b = 1'b1; we_b = 1'b0; sel_b = 4'hF; adr_b = 32'h3800_000C;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ack_b) begin
        acks_b++;
        if (first_c < 0) first_c = c; else second_c = c;
        if (q_b.size() > 0) begin
          exp_d = q_b.pop_front();
          chk("b2b_data", dato_b, exp_d);
        end
        stb_b = 1'b0;
      end
      if (c == 3) begin
        q_b.push_back(32'hA5A5_0007);
        @(posedge clk); #1;
        stb_b = 1'b1; adr_b = 32'h3800_001C;
      end
    end
    cyc_b = 1'b0; stb_b = 1'b0;
    chk("b2b_ack_count", acks_b, 32'd2);
    chk("b2b_first_ack", first_c, 32'd2);
    chk("b2b_second_ack", second_c, 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
